// File: rtl/mdio_pkg.sv
// mdio_pkg
// Shared constants and the frame-sequencing state type for the clause-22
// MDIO master. Field codes are transmitted MSB first.
//
// Optional build macro: MDIO_PREAMBLE_EN (used by mdio_master; when it is
// undefined the preamble is suppressed).
`timescale 1ns/1ps
package mdio_pkg;

   // Frame field codes
   localparam logic [1:0] ST       = 2'b01;
   localparam logic [1:0] OP_READ  = 2'b10;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] TA_WRITE = 2'b10;

   // Field lengths in bits
   localparam int PREAMBLE_BITS = 32;
   localparam int HEADER_BITS   = 14;
   localparam int TA_BITS       = 2;
   localparam int DATA_BITS     = 16;

   // Frame sequencing states
   typedef enum logic [2:0] {
      IDLE,
      PREAMBLE,
      HEADER,
      TA,
      DATA
   } state_t;

endpackage

// File: rtl/mdc_phase_gen.sv
// mdc_phase_gen
// Divides the system clock into MDC bit periods while a frame is running.
// MDC is low for MDC_DIV clocks then high for MDC_DIV clocks; it rests at 0
// whenever enable is low.
//
// Ports:
//   clock        system clock
//   reset_n      asynchronous active-low reset
//   enable       high while a frame is in progress
//   mdc_pin      registered management clock
//   fall_strobe  high in the cycle whose closing edge drives MDC 1->0
//                (bit boundary: MDIO drive point and read sample point)
//   rise_strobe  high in the cycle whose closing edge drives MDC 0->1
`timescale 1ns/1ps
module mdc_phase_gen #(
   parameter int MDC_DIV = 1
) (
   input  logic clock,
   input  logic reset_n,
   input  logic enable,
   output logic mdc_pin,
   output logic fall_strobe,
   output logic rise_strobe
);

   localparam int CW = (MDC_DIV > 1) ? $clog2(MDC_DIV) : 1;

   logic [CW-1:0] div_cnt;
   logic          half_done;

   // A half-period ends on the last of its MDC_DIV clocks; the strobes tell
   // which way MDC is about to toggle on that edge.
   assign half_done   = enable && (div_cnt == CW'(MDC_DIV - 1));
   assign rise_strobe = half_done && !mdc_pin;
   assign fall_strobe = half_done && mdc_pin;

   // Divider counter and MDC register; both restart from zero for each
   // frame so the first bit always begins with a full low half-period.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt <= '0;
         mdc_pin <= 1'b0;
      end else if (!enable) begin
         div_cnt <= '0;
         mdc_pin <= 1'b0;
      end else if (half_done) begin
         div_cnt <= '0;
         mdc_pin <= ~mdc_pin;
      end else begin
         div_cnt <= div_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/mdio_master.sv
// mdio_master
// IEEE 802.3 clause-22 MDIO master: serialises one register read or write
// per request into an MDC/MDIO frame and returns read data.
//
// Parameters:
//   PHY_ADDR  PHYAD field of every frame
//   MDC_DIV   clocks per MDC half-period
// Ports:
//   clock       system clock
//   reset_n     asynchronous active-low reset
//   addr        register address, sampled at accept
//   wr_data     write data, sampled at accept
//   rd_request  read request strobe
//   wr_request  write request strobe (wins over a simultaneous read)
//   ready       idle with no request present
//   rd_data     data from the last completed read
//   mdio_pin    MDIO line, driven or released to the external pull-up
//   mdc_pin     management clock
//
// Build macro MDIO_PREAMBLE_EN: defined sends the 32-bit preamble; undefined
// suppresses it and frames start at ST.
`timescale 1ns/1ps
module mdio_master
   import mdio_pkg::*;
#(
   parameter logic [4:0] PHY_ADDR = 5'd0,
   parameter int         MDC_DIV  = 1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [4:0]  addr,
   input  logic [15:0] wr_data,
   input  logic        rd_request,
   input  logic        wr_request,
   output logic        ready,
   output logic [15:0] rd_data,
   inout  wire         mdio_pin,
   output logic        mdc_pin
);

`ifdef MDIO_PREAMBLE_EN
   localparam state_t FRAME_START = PREAMBLE;
`else
   localparam state_t FRAME_START = HEADER;
`endif

   state_t      state, state_next;
   logic [5:0]  bit_cnt;
   logic [5:0]  state_bits;
   logic [31:0] shift_out;
   logic [15:0] shift_in;
   logic        op_write;
   logic        mdio_o, mdio_oe;
   logic        mdio_o_next, mdio_oe_next;
   logic        accept, last_bit;
   logic        fall_strobe, rise_strobe;

   mdc_phase_gen #(.MDC_DIV(MDC_DIV)) u_phase (
      .clock       (clock),
      .reset_n     (reset_n),
      .enable      (state != IDLE),
      .mdc_pin     (mdc_pin),
      .fall_strobe (fall_strobe),
      .rise_strobe (rise_strobe)
   );

   assign accept   = (state == IDLE) && (rd_request || wr_request);
   assign ready    = (state == IDLE) && !rd_request && !wr_request;
   assign mdio_pin = mdio_oe ? mdio_o : 1'bz;

   // bit_cnt counts MDC rises seen in the current state, so at the closing
   // fall of a state's final bit it equals that state's length.
   assign last_bit = fall_strobe && (bit_cnt == state_bits);

   // Length of each state in bits
   always_comb begin
      state_bits = 6'd0;
      case (state)
         PREAMBLE: state_bits = 6'(PREAMBLE_BITS);
         HEADER:   state_bits = 6'(HEADER_BITS);
         TA:       state_bits = 6'(TA_BITS);
         DATA:     state_bits = 6'(DATA_BITS);
         default:  state_bits = 6'd0;
      endcase
   end

   // Next state and the MDIO value/enable for the bit that starts on the
   // coming edge. During the preamble the shift register is held, so the
   // first header bit is still at the top when the preamble ends. Reads
   // release the line from the first TA bit; writes release after the last
   // data bit.
   always_comb begin
      state_next   = state;
      mdio_o_next  = mdio_o;
      mdio_oe_next = mdio_oe;
      case (state)
         IDLE:     if (accept)   state_next = FRAME_START;
         PREAMBLE: if (last_bit) state_next = HEADER;
         HEADER:   if (last_bit) state_next = TA;
         TA:       if (last_bit) state_next = DATA;
         DATA:     if (last_bit) state_next = IDLE;
         default:                state_next = IDLE;
      endcase
      if (accept) begin
         mdio_o_next  = (FRAME_START == PREAMBLE) ? 1'b1 : ST[1];
         mdio_oe_next = 1'b1;
      end else if (fall_strobe) begin
         if (state_next == IDLE) begin
            mdio_o_next  = 1'b1;
            mdio_oe_next = 1'b0;
         end else begin
            if (state_next == PREAMBLE)
               mdio_o_next = 1'b1;
            else if (state == PREAMBLE)
               mdio_o_next = shift_out[31];
            else
               mdio_o_next = shift_out[30];
            mdio_oe_next = op_write || (state_next == PREAMBLE) || (state_next == HEADER);
         end
      end
   end

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Frame datapath: bit counter, shift registers, MDIO drive registers and
   // the read-data result. Read data is sampled at each MDC falling edge and
   // published on the edge that returns to IDLE.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt   <= 6'd0;
         shift_out <= 32'd0;
         shift_in  <= 16'd0;
         op_write  <= 1'b0;
         mdio_o    <= 1'b1;
         mdio_oe   <= 1'b0;
         rd_data   <= 16'h0000;
      end else begin
         mdio_o  <= mdio_o_next;
         mdio_oe <= mdio_oe_next;
         if (state_next != state)
            bit_cnt <= 6'd0;
         else if (rise_strobe)
            bit_cnt <= bit_cnt + 6'd1;
         if (accept) begin
            op_write  <= wr_request;
            shift_out <= {ST, (wr_request ? OP_WRITE : OP_READ), PHY_ADDR, addr, TA_WRITE, wr_data};
         end else if (fall_strobe && (state != PREAMBLE)) begin
            shift_out <= {shift_out[30:0], 1'b0};
         end
         if (fall_strobe && (state == DATA)) begin
            shift_in <= {shift_in[14:0], mdio_pin};
            if (last_bit && !op_write)
               rd_data <= {shift_in[14:0], mdio_pin};
         end
      end
   end

endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master
// Self-checking bench for mdio_master. A frame-level model predicts ready,
// mdc_pin, the MDIO line level and rd_data every cycle; a simple PHY model
// answers reads; directed transactions add literal expectations for frame
// contents, latency and reset behaviour. Works with or without
// MDIO_PREAMBLE_EN.
`timescale 1ns/1ps
module tb_mdio_master;

   localparam int         D   = 1;
   localparam logic [4:0] PHY = 5'd0;
`ifdef MDIO_PREAMBLE_EN
   localparam int PRE       = 32;
   localparam int LAT_LIT   = 128;
   localparam int ABORT_BIT = 40;
`else
   localparam int PRE       = 0;
   localparam int LAT_LIT   = 64;
   localparam int ABORT_BIT = 8;
`endif
   localparam int N         = PRE + 32;
   localparam int HDR       = PRE + 14;
   localparam int LAT_BOUND = 1000;

   logic        clock, reset_n;
   logic [4:0]  addr;
   logic [15:0] wr_data;
   logic        rd_request, wr_request;
   logic        ready;
   logic [15:0] rd_data;
   logic        mdc_pin;
   wire         mdio_line;

   logic        phy_o, phy_oe;
   logic [15:0] phy_data;

   logic        model_busy;
   logic        model_read;
   int          k;
   logic [63:0] exp_frame;
   logic [15:0] exp_rd;
   logic [63:0] cap_frame;

   int checks = 0;
   int errors = 0;

   pullup (mdio_line);
   assign mdio_line = phy_oe ? phy_o : 1'bz;

   mdio_master #(.PHY_ADDR(PHY), .MDC_DIV(D)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .addr       (addr),
      .wr_data    (wr_data),
      .rd_request (rd_request),
      .wr_request (wr_request),
      .ready      (ready),
      .rd_data    (rd_data),
      .mdio_pin   (mdio_line),
      .mdc_pin    (mdc_pin)
   );

   // 2.5 MHz system clock
   initial begin
      clock = 1'b0;
      forever #200 clock = ~clock;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame model: on accept the whole expected line sequence is built as one
   // vector (for reads the TA pair reads 1 from the pull-up then 0 from the
   // PHY, and the data comes from the PHY). k counts clocks since accept.
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         model_busy <= 1'b0;
         model_read <= 1'b0;
         k          <= 0;
         exp_rd     <= 16'h0000;
      end else if (!model_busy) begin
         if (rd_request || wr_request) begin
            model_busy <= 1'b1;
            model_read <= !wr_request;
            k          <= 0;
            exp_frame  <= {32'hFFFF_FFFF, 2'b01, (wr_request ? 2'b01 : 2'b10), PHY, addr, 2'b10,
                           (wr_request ? wr_data : phy_data)};
         end
      end else begin
         k <= k + 1;
         if (k + 1 == 2 * D * N) begin
            model_busy <= 1'b0;
            if (model_read)
               exp_rd <= phy_data;
         end
      end
   end

   // PHY model: shortly after each MDC fall it drives the second TA bit and
   // the read data bits, and lets go otherwise.
   always @(negedge mdc_pin or negedge reset_n) begin
      int b;
      #100;
      b = k / (2 * D);
      if (model_busy && model_read && b == HDR + 1) begin
         phy_oe <= 1'b1;
         phy_o  <= 1'b0;
      end else if (model_busy && model_read && b >= HDR + 2 && b < N) begin
         phy_oe <= 1'b1;
         phy_o  <= phy_data[N - 1 - b];
      end else begin
         phy_oe <= 1'b0;
         phy_o  <= 1'b1;
      end
   end

   // Line level captured at each MDC rise, stored by frame bit position
   always @(posedge mdc_pin) begin
      #1;
      if (model_busy)
         cap_frame[N - 1 - (k / (2 * D))] <= mdio_line;
   end

   // Per-cycle comparison against the frame model
   always @(negedge clock) begin
      int   bidx;
      logic exp_mdc, exp_line;
      if (model_busy) begin
         bidx     = k / (2 * D);
         exp_mdc  = (k % (2 * D)) >= D;
         exp_line = exp_frame[N - 1 - bidx];
      end else begin
         exp_mdc  = 1'b0;
         exp_line = 1'b1;
      end
      checkOutput("ready", ready, !model_busy && !rd_request && !wr_request);
      checkOutput("mdc", mdc_pin, exp_mdc);
      checkOutput("mdio", mdio_line, exp_line);
      checkOutput("rd_data", rd_data, exp_rd);
   end

   // Presents one request starting now (just after a clock edge), then waits
   // for ready, optionally pulsing a write request mid-frame or aborting the
   // frame with a reset pulse at a given bit.
   task automatic applyStimulus(input logic rd, input logic wr, input logic [4:0] a,
                                input logic [15:0] d, input int pulse_bit,
                                input int abort_bit, output int lat);
      int n;
      rd_request = rd;
      wr_request = wr;
      addr       = a;
      wr_data    = d;
      #10;
      checkOutput("ready_in_req_cycle", ready, 1'b0);
      @(posedge clock);
      #1;
      rd_request = 1'b0;
      wr_request = 1'b0;
      addr       = 5'($urandom);
      wr_data    = 16'($urandom);
      n   = 0;
      lat = -1;
      while (n < LAT_BOUND) begin
         if (abort_bit >= 0 && n == 2 * D * abort_bit) begin
            #50;
            reset_n = 1'b0;
            #1;
            checkOutput("abort_mdc", mdc_pin, 1'b0);
            checkOutput("abort_mdio", mdio_line, 1'b1);
            checkOutput("abort_ready", ready, 1'b1);
            checkOutput("abort_rd_data", rd_data, 16'h0000);
            @(posedge clock);
            @(posedge clock);
            #1;
            reset_n = 1'b1;
            return;
         end
         wr_request = (pulse_bit >= 0 && n == 2 * D * pulse_bit);
         @(posedge clock);
         #1;
         n++;
         if (ready) begin
            lat = n;
            break;
         end
      end
      if (lat < 0)
         lat = n;
   endtask

   initial begin
      int lat;
      reset_n    = 1'b0;
      rd_request = 1'b0;
      wr_request = 1'b0;
      addr       = 5'd0;
      wr_data    = 16'd0;
      phy_data   = 16'd0;
      repeat (3) @(posedge clock);
      #1;
      checkOutput("reset_mdc", mdc_pin, 1'b0);
      checkOutput("reset_mdio", mdio_line, 1'b1);
      checkOutput("reset_ready", ready, 1'b1);
      checkOutput("reset_rd_data", rd_data, 16'h0000);
      reset_n = 1'b1;

      $display("[TB] write 0x0002 to reg 0x0d");
      applyStimulus(1'b0, 1'b1, 5'h0d, 16'h0002, -1, -1, lat);
      checkOutput("wr_latency", lat, LAT_LIT);
      checkOutput("wr_frame", cap_frame[31:0], 32'h5036_0002);
`ifdef MDIO_PREAMBLE_EN
      checkOutput("wr_preamble", cap_frame[63:32], 32'hFFFF_FFFF);
`endif

      $display("[TB] read reg 0x1f, PHY returns 0x0260");
      phy_data = 16'h0260;
      applyStimulus(1'b1, 1'b0, 5'h1f, 16'hFFFF, -1, -1, lat);
      checkOutput("rd_latency", lat, LAT_LIT);
      checkOutput("rd_value", rd_data, 16'h0260);
      checkOutput("rd_frame", cap_frame[31:0], 32'h607E_0260);

      $display("[TB] simultaneous read and write");
      applyStimulus(1'b1, 1'b1, 5'h03, 16'hBEEF, -1, -1, lat);
      checkOutput("both_latency", lat, LAT_LIT);
      checkOutput("both_op", cap_frame[29:28], 2'b01);
      checkOutput("both_data", cap_frame[15:0], 16'hBEEF);
      checkOutput("both_rd_kept", rd_data, 16'h0260);

      $display("[TB] write request while a read is busy");
      phy_data = 16'hA5C3;
      applyStimulus(1'b1, 1'b0, 5'h01, 16'h0000, 5, -1, lat);
      checkOutput("busy_latency", lat, LAT_LIT);
      checkOutput("busy_op", cap_frame[29:28], 2'b10);
      checkOutput("busy_rd_value", rd_data, 16'hA5C3);

      $display("[TB] reset pulse mid-frame");
      applyStimulus(1'b0, 1'b1, 5'h02, 16'h1234, -1, ABORT_BIT, lat);
      applyStimulus(1'b0, 1'b1, 5'h05, 16'h8001, -1, -1, lat);
      checkOutput("post_abort_latency", lat, LAT_LIT);
      checkOutput("post_abort_frame", cap_frame[31:0], 32'h5016_8001);

      repeat (4) @(posedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mdio_master.md
# mdio_master

IEEE 802.3 clause-22 MDIO management master that serialises single register read/write requests into MDC/MDIO frames for the Ethernet PHY. It sits directly downstream of `phy_cfg`, which supplies the register address, the write data and one-cycle request strobes, and waits on `ready`. It returns 16-bit read data to `phy_cfg` for the PHY status poll.

## Interface
- `PHY_ADDR`, default 5'd0: PHY address placed in the PHYAD field of every frame.
- `MDC_DIV`, default 1: number of `clock` cycles per MDC half-period. Bit time is 2*MDC_DIV clocks.
- `clock`  in  1  system clock, 2.5 MHz.
- `reset_n`  in  1  asynchronous, active-low reset.
- `addr`  in  5  register address (REGAD). Sampled at accept.
- `wr_data`  in  16  write data. Sampled at accept.
- `rd_request`  in  1  read request strobe.
- `wr_request`  in  1  write request strobe.
- `ready`  out  1  idle and able to accept a request.
- `rd_data`  out  16  data from the last completed read.
- `mdio_pin`  inout  1  MDIO line. Driven or released (Z); an external pull-up holds it high when released.
- `mdc_pin`  out  1  management clock.

## Operation
- `ready` = (state == IDLE) & ~rd_request & ~wr_request.
  - It drops combinationally in the cycle a request is presented, so a registered requester never issues a second request.
- Accept occurs on the rising `clock` edge where state == IDLE and either request is high.
  - At accept, `addr` and `wr_data` are latched and the operation is latched.
  - If both requests are high, the write wins and the read is dropped.
- Requests presented while busy are ignored. They are not queued.
- Frame bits are sent MSB first:
  - preamble: 32 × '1'
  - ST = 01
  - OP = 10 for read, 01 for write
  - PHYAD = PHY_ADDR
  - REGAD = addr
  - TA
  - DATA[15:0]
- Write frames:
  - The master drives every bit; TA = 10.
  - MDIO is released after the last data bit.
- Read frames:
  - MDIO is released from the first TA bit through the end of the frame.
  - The second TA bit (PHY '0') is not checked.
  - Data bits are shifted into a 16-bit register.
- States and transitions:
  - IDLE → PREAMBLE (32 bits) → HEADER (14 bits: ST, OP, PHYAD, REGAD) → TA (2 bits) → DATA (16 bits) → IDLE.
  - Each state advances at the end of its last bit.
- `rd_data` is updated only at the end of a read, on the same edge at which state returns to IDLE. Writes never alter it.
- Reset values: state IDLE, `mdc_pin` 0, MDIO released, `rd_data` 16'h0000. `ready` is therefore 1 when no request is present.
- Reset asserted mid-frame:
  - Immediate abort; outputs go to their reset values.
  - The partial frame is abandoned. The PHY resynchronises on the next preamble.
  - `rd_data` is cleared.

## Timing
- Each bit is 2*MDC_DIV clocks: MDC low for MDC_DIV clocks, then high for MDC_DIV clocks.
- MDIO output changes only on the clock edge that drives MDC low. Data is stable for a full half-period before MDC rises.
- Read sampling: the bit is sampled on the clock edge that drives MDC from 1 to 0, i.e. MDC_DIV clocks after the rising edge. This gives ≥400 ns of PHY output delay margin at default settings.
- MDC frequency = clock / (2*MDC_DIV), i.e. 1.25 MHz by default, below the 2.5 MHz limit.
- Latency: `ready` reasserts exactly 2*MDC_DIV*N clocks after the accept edge. N = 64 with preamble, 32 without.
- After completion, `mdc_pin` idles at 0 and MDIO is released. Back-to-back requests are legal on the first `ready` cycle.

## Configuration
- `MDIO_PREAMBLE_EN` defined: the full 32-bit preamble is sent and N = 64.
- `MDIO_PREAMBLE_EN` undefined: preamble suppression. PREAMBLE is skipped, the frame starts at ST and N = 32.
  - This mode is only valid with PHYs that support preamble suppression.

## Structure
- Package `mdio_pkg` holds:
  - ST = 2'b01, OP_READ = 2'b10, OP_WRITE = 2'b01, TA_WRITE = 2'b10
  - PREAMBLE_BITS = 32, HEADER_BITS = 14, DATA_BITS = 16
  - the state enum
- Sub-module `mdc_phase_gen` contains the MDC_DIV counter and `mdc_pin` register. It emits `fall_strobe` (drive/sample point) and `rise_strobe`.
- The top level contains the FSM, a bit counter, a shift-out register, a shift-in register and the tri-state control.

## Test plan
- Reset: hold `reset_n` low → `mdc_pin` = 0, MDIO = Z, `ready` = 1, `rd_data` = 16'h0000.
- Write, addr 5'h0d, wr_data 16'h0002, PHY_ADDR 0:
  - Bits captured on MDC rise are 32×1, 01, 01, 00000, 01101, 10, 0000000000000010.
  - `ready` returns after 128 clocks.
- Read, addr 5'h1f, with a PHY model driving 16'h0260 after TA:
  - MDIO is Z from TA onward.
  - `rd_data` = 16'h0260 on the edge where `ready` rises.
- Simultaneous rd_request and wr_request:
  - A write frame (OP 01) is sent.
  - `rd_data` is unchanged.
  - `ready` is low in the request cycle.
- Request while busy:
  - The request is ignored.
  - Reset pulsed at bit 40 → immediate IDLE with MDIO = Z.
  - The next request produces a complete 64-bit frame.
- Built without `MDIO_PREAMBLE_EN`: the frame starts directly with 01, and `ready` returns after 64 clocks.
